nios_debug_jtag_scan_host: RTL

//  Initiator side of the Nios II debug-slave virtual-JTAG link. Converts one command
//  (IR value plus DR word) into a full virtual-JTAG scan: UIR, CDR, SDR shift, UDR, RTI.

---
 rtl/nios_debug_jtag_scan_host.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/nios_debug_jtag_scan_host.sv
`default_nettype none
// ============================================================================
// Module   : nios_debug_jtag_scan_host
// Purpose  : Initiator side of the Nios II debug-slave virtual-JTAG link.
//            Converts one command (IR value + DR word) into a complete
//            virtual-JTAG scan (UIR, CDR, SDR shift, UDR, RTI). It drives the
//            vji_* strobes, tck and tdi, and returns the captured tdo word.
//            It stands in for sld_virtual_jtag_basic in simulation and in
//            fabric self-test of the debug_slave_tck / debug_slave_sysclk pair.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   DR_WIDTH  data-register scan length in bits
//   IR_WIDTH  virtual IR width
//   TCK_DIV   tck half-period in clk cycles (>= 1)
// Ports
//   clk, reset_n             system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_ir, cmd_dr           IR value and DR word (shifted LSB first)
//   rsp_valid                one-clk response pulse, no backpressure
//   rsp_dr, rsp_ir_out       captured tdo word, vji_ir_out seen in CDR
//   vji_tck, vji_tdi         generated scan clock and serial data out
//   vji_tdo, vji_ir_out      serial data and status IR from the slave
//   vji_ir_in                virtual IR presented to the slave
//   vji_uir/cdr/sdr/udr/rti  virtual state strobes
// Configuration macro
//   NIOS_JTAG_SCAN_IR_CACHE_EN  when defined, a scan whose IR matches the
//   last issued IR (after at least one completed scan) skips the UIR state.
// ============================================================================
module nios_debug_jtag_scan_host #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int c_cnt_w = $clog2(DR_WIDTH + 1);
    localparam int c_div_w = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(TCK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_bits     = c_cnt_w'(DR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_UDR  = 3'd4,
        S_RTI  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_init;       // low until the first clk after reset release
    logic                  r_tck;
    logic [c_div_w-1:0]    r_div;
    logic                  r_rti_fell;   // final tck fall of RTI has happened
    logic [DR_WIDTH-1:0]   r_sr;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_tdi;
    logic [IR_WIDTH-1:0]   r_ir_in;
    logic [IR_WIDTH-1:0]   r_ir_cap;
    logic                  r_rsp_valid;
    logic [DR_WIDTH-1:0]   r_rsp_dr;
    logic [IR_WIDTH-1:0]   r_rsp_ir;

    logic                  w_accept;
    logic                  w_run;
    logic                  w_tick;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_ir_hit;

    assign cmd_ready = r_init && (r_state == S_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    // tck runs only between acceptance and the last fall of RTI.
    assign w_run  = (r_state != S_IDLE) && (r_state != S_DONE) && !r_rti_fell;
    assign w_tick = w_run && (r_div == c_div_last);
    assign w_rise = w_tick && !r_tck;
    assign w_fall = w_tick &&  r_tck;

`ifdef NIOS_JTAG_SCAN_IR_CACHE_EN
    // r_ir_in already holds the last issued IR; only a validity bit is needed.
    logic r_cache_vld;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cache_vld <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_cache_vld <= 1'b1;
        end
    end

    assign w_ir_hit = r_cache_vld && (cmd_ir == r_ir_in);
`else
    assign w_ir_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Scan clock generator: toggles every TCK_DIV clks while running and
    // restarts low on every acceptance.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
            r_tck <= 1'b0;
        end else if (!w_run) begin
            r_div <= '0;
            r_tck <= 1'b0;
        end else if (w_tick) begin
            r_div <= '0;
            r_tck <= !r_tck;
        end else begin
            r_div <= r_div + c_div_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Scan states advance only on tck falling edges so
    // strobes are stable around every rising edge. RTI leaves one clk after
    // its final fall so that DONE holds tck low for the response cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_ir_hit ? S_CDR : S_UIR;
            S_UIR:  if (w_fall)   w_state_next = S_CDR;
            S_CDR:  if (w_fall)   w_state_next = S_SDR;
            S_SDR:  if (w_fall && (r_cnt == c_bits)) w_state_next = S_UDR;
            S_UDR:  if (w_fall)   w_state_next = S_RTI;
            S_RTI:  if (r_rti_fell) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, bit counter, tdi, IR capture, response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init      <= 1'b0;
            r_rti_fell  <= 1'b0;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_tdi       <= 1'b0;
            r_ir_in     <= '0;
            r_ir_cap    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dr    <= '0;
            r_rsp_ir    <= '0;
        end else begin
            r_init      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rti_fell  <= (r_state == S_RTI) && w_fall;

            if (w_accept) begin
                r_sr    <= cmd_dr;
                r_ir_in <= cmd_ir;
                r_cnt   <= '0;
                r_tdi   <= 1'b0;
            end

            if (w_rise) begin
                if (r_state == S_CDR) begin
                    r_ir_cap <= vji_ir_out;
                end
                if (r_state == S_SDR) begin
                    r_sr  <= {vji_tdo, r_sr[DR_WIDTH-1:1]};
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end

            // The shift on the preceding rise has already exposed the next
            // outgoing bit in r_sr[0]; tdi picks it up on the fall.
            if (w_fall) begin
                r_tdi <= (w_state_next == S_SDR) ? r_sr[0] : 1'b0;
            end

            if ((r_state == S_RTI) && (w_state_next == S_DONE)) begin
                r_rsp_valid <= 1'b1;
                r_rsp_dr    <= r_sr;
                r_rsp_ir    <= r_ir_cap;
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_dr     = r_rsp_dr;
    assign rsp_ir_out = r_rsp_ir;
    assign vji_tck    = r_tck;
    assign vji_tdi    = r_tdi;
    assign vji_ir_in  = r_ir_in;
    assign vji_uir    = (r_state == S_UIR);
    assign vji_cdr    = (r_state == S_CDR);
    assign vji_sdr    = (r_state == S_SDR);
    assign vji_udr    = (r_state == S_UDR);
    assign vji_rti    = (r_state == S_RTI) || (r_state == S_IDLE) || (r_state == S_DONE);

endmodule
`default_nettype wire
